// File: rtl/compas_input_pkg.sv
// rtl/compas_input_pkg.sv - register map constants and helpers for the debounced input block
package compas_input_pkg;

    localparam logic [3:0] ADDR_MASK  = 4'd8;
    localparam logic [3:0] ADDR_FLAGS = 4'd9;
    localparam logic [3:0] ADDR_ID    = 4'd10;
    localparam logic [7:0] ID_BYTE    = 8'hCA;

    // Debounce counter never needs to hold more than DEBOUNCE-1; keep at least one bit.
    function automatic int cnt_width(input int debounce);
        return (debounce < 2) ? 1 : $clog2(debounce);
    endfunction

endpackage

// File: rtl/compas_input_debounce.sv
// rtl/compas_input_debounce.sv - one channel: synchroniser, candidate/count debouncer, change pulse
module compas_input_debounce
    import compas_input_pkg::*;
#(
    parameter int WIDTH       = 9,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] filtered,
    output logic             change
);

    localparam int            CW       = cnt_width(DEBOUNCE);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] candidate;
    logic [CW-1:0]    count;

    assign sync = sync_q[SYNC_STAGES-1];

    // Combinational so the top-level flag sets on the same edge filtered takes the new value.
    assign change = (sync == candidate) && (candidate != filtered) && (count == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            candidate <= '0;
            count     <= '0;
            filtered  <= '0;
        end else if (sync != candidate) begin
            candidate <= sync;
            count     <= '0;
        end else if (change) begin
            filtered  <= candidate;
            count     <= '0;
        end else if (candidate != filtered) begin
            count     <= count + CW'(1);
        end else begin
            count     <= '0;
        end
    end

endmodule

// File: rtl/compas_input_multi.sv
// rtl/compas_input_multi.sv - multi-channel debounced input port with flags, mask, irq and register read-back
module compas_input_multi
    import compas_input_pkg::*;
#(
    parameter int WIDTH       = 9,
    parameter int CHANNELS    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3:0]                address,
    input  logic                      read,
    input  logic                      write,
    input  logic [31:0]               writedata,
    output logic [31:0]               readdata,
    input  logic [CHANNELS*WIDTH-1:0] in_port,
    output logic                      irq
);

    logic [WIDTH-1:0]    filtered [CHANNELS];
    logic [CHANNELS-1:0] change;
    logic [CHANNELS-1:0] change_flags;
    logic [CHANNELS-1:0] irq_mask;
    logic [CHANNELS-1:0] flag_clear;
    logic [31:0]         rd_mux;
    logic                wr_mask;
    logic                wr_flags;
    logic                unused_bits;

    // Reads are side-effect free, so the strobe and high write bits carry no meaning here.
    assign unused_bits = ^{read, writedata[31:CHANNELS]};

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            compas_input_debounce #(
                .WIDTH       (WIDTH),
                .SYNC_STAGES (SYNC_STAGES),
                .DEBOUNCE    (DEBOUNCE)
            ) u_debounce (
                .clk      (clk),
                .reset    (reset),
                .raw      (in_port[c*WIDTH +: WIDTH]),
                .filtered (filtered[c]),
                .change   (change[c])
            );
        end
    endgenerate

    assign wr_mask    = write && (address == ADDR_MASK);
    assign wr_flags   = write && (address == ADDR_FLAGS);
    assign flag_clear = wr_flags ? writedata[CHANNELS-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (address == 4'(c)) begin
                rd_mux = 32'(filtered[c]);
            end
        end
        if (address == ADDR_MASK) begin
            rd_mux = 32'(irq_mask);
        end else if (address == ADDR_FLAGS) begin
            rd_mux = 32'(change_flags);
        end else if (address == ADDR_ID) begin
            rd_mux = {ID_BYTE, 8'(CHANNELS), 8'(WIDTH), 8'(DEBOUNCE)};
        end
    end

    // A new change outranks a simultaneous write-1-to-clear of the same bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            change_flags <= '0;
            irq_mask     <= '0;
            readdata     <= '0;
        end else begin
            change_flags <= (change_flags & ~flag_clear) | change;
            if (wr_mask) begin
                irq_mask <= writedata[CHANNELS-1:0];
            end
            readdata     <= rd_mux;
        end
    end

    assign irq = |(change_flags & irq_mask);

endmodule
